spec_ghr_ckpt: RTL and testbench
================================

Name: spec_ghr_ckpt

Overview:
Parametrised speculative global history register for the superscalar out-of-order front end. Shifts in up to WIDTH predicted branch outcomes per fetch group and snapshots the pre-branch history of every branch into a circular checkpoint table. On a misprediction it restores the history as checkpoint plus actual outcome and squashes all younger checkpoints. Feeds the predictor index path via a one-cycle-registered copy, ghr_F.

Parameters:
HIST_LEN, 5, history length in bits (>= WIDTH+1)
WIDTH, 2, branch lanes per fetch group
DEPTH, 8, checkpoint entries (power of two, >= WIDTH)
ID_W, $clog2(DEPTH), checkpoint id width

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
grp_valid  in  1  fetch group presented
is_branch  in  WIDTH  lane i holds a predicted branch; lane 0 is oldest
pred_taken  in  WIDTH  predicted direction per lane
grp_ready  out  1  group can be accepted this cycle (combinational)
ckpt_id  out  WIDTH*ID_W  id allocated to lane i (valid when grp_valid&grp_ready&is_branch[i])
commit_valid  in  1  oldest checkpoint retires
mispred_valid  in  1  branch resolved mispredicted
mispred_id  in  ID_W  checkpoint id of mispredicted branch
mispred_taken  in  1  actual direction
ghr_F  out  HIST_LEN  spec history delayed one cycle
ckpt_count  out  ID_W+1  live checkpoints

Behaviour:
- Reset (reset==0 at posedge): spec history, ghr_F, head, tail, ckpt_count = 0. Checkpoint table contents are don't-care. Reset overrides every other input, including in mid-recovery.
- grp_ready = !mispred_valid && (ckpt_count <= DEPTH-WIDTH). This is conservative: the group width always fits.
- Accept = grp_valid && grp_ready. k = popcount(is_branch); k=0 is legal and leaves the history unchanged.
- Update: the history shifts left by k, and the taken bits of the branch lanes are inserted in lane order, with the oldest bit in the higher position. For WIDTH=2, both lanes give {h[HIST_LEN-3:0], t0, t1}; one lane gives {h[HIST_LEN-2:0], t}.
- Lane i branch gets id = (tail + number of branch lanes below i) mod DEPTH. ckpt[id] <= history just before that branch's bit is inserted, so it includes the bits of older lanes in the same group. tail += k.
- Commit: head += 1 and count -= 1. Committing with count==0 is ignored.
- Mispredict, which has priority over accept: spec <= {ckpt[mispred_id][HIST_LEN-2:0], mispred_taken}; tail <= mispred_id+1 mod DEPTH. The mispredicted branch stays live, younger entries are freed.
- Count after a mispredict = ((mispred_id - head) mod DEPTH) + 1 - (commit_valid ? 1 : 0).
- Commit and mispredict may occur in the same cycle. Both take effect. Commit of the mispredicted entry itself in that same cycle is permitted and yields count = (id-head) mod DEPTH.
- A mispred_id outside the live range is a protocol error, with undefined result; an assertion is required.
- ghr_F <= spec history every cycle, a 1-cycle latency. The restored value appears on ghr_F the cycle after the restore.
- Wrap-around: head and tail wrap modulo DEPTH. Count is kept separately to distinguish full from empty.

Decomposition:
- Shared package (bp_pkg): HIST_LEN and WIDTH defaults, ckpt_id_t typedef, and a shift_in_outcomes function shared with the predictor.
- One natural sub-module: ghr_ckpt_table, a DEPTH x HIST_LEN register file with WIDTH write ports and 1 async read port.
- Pointer/count logic stays in the top.

Test Plan:
(All cases use HIST_LEN=5, WIDTH=2, DEPTH=4.)
- Reset: hold reset=0 two cycles with grp_valid=1 -> ghr_F=00000, ckpt_count=0, grp_ready=1.
- Dual branch: is_branch=11, pred_taken t0=1,t1=0 -> ids 0,1; ckpt[0]=00000, ckpt[1]=00001; spec=00010; ghr_F=00010 one cycle later; count=2.
- Single lane: next group is_branch=10 (lane1 only), taken=1 -> id 2, spec=00101, count=3, grp_ready=0. A further grp_valid is ignored and history is unchanged.
- Mispredict: mispred_id=1, mispred_taken=1 -> spec=00011, tail=2, count=2, grp_ready=1. ghr_F=00011 next cycle.
- Commit+mispredict same cycle: head=0, count=2, commit_valid=1 with mispred_id=1, taken=0 -> spec=00010, head=1, count=1.
- Wrap and reset: issue branches until tail wraps 3->0 while committing. Check ids reuse 0 and count never exceeds 4. Assert reset=0 during mispred_valid -> all state 0 next cycle.

Source files
------------

// File: rtl/spec_ghr_ckpt_pkg.sv
// Shared branch-predictor definitions: default geometry, checkpoint id type and
// the history shift helper used by both the GHR and the predictor index path.
package spec_ghr_ckpt_pkg;

    localparam int HIST_LEN_DEF  = 5;
    localparam int WIDTH_DEF     = 2;
    localparam int DEPTH_DEF     = 8;
    localparam int CKPT_ID_W_DEF = $clog2(DEPTH_DEF);

    localparam int HIST_MAX = 64;
    localparam int LANE_MAX = 8;

    typedef logic [CKPT_ID_W_DEF-1:0] ckpt_id_t;
    typedef logic [HIST_MAX-1:0]      hist_max_t;
    typedef logic [LANE_MAX-1:0]      lane_vec_t;

    // Lane 0 is oldest, so it is shifted in first and ends up in the higher bit.
    function automatic hist_max_t shift_in_outcomes(input hist_max_t   hist,
                                                    input lane_vec_t   is_br,
                                                    input lane_vec_t   taken,
                                                    input int unsigned lanes);
        hist_max_t h_v;
        h_v = hist;
        for (int unsigned i = 32'd0; i < LANE_MAX; i++) begin
            if ((i < lanes) && is_br[i]) begin
                h_v = {h_v[HIST_MAX-2:0], taken[i]};
            end
        end
        return h_v;
    endfunction

endpackage

// File: rtl/spec_ghr_ckpt_if.sv
// Front-end <-> speculative GHR handshake: fetch-group allocation, commit,
// mispredict recovery and the registered history fed to the predictor.
interface spec_ghr_ckpt_if
    import spec_ghr_ckpt_pkg::*;
#(
    parameter int HIST_LEN = HIST_LEN_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ID_W     = CKPT_ID_W_DEF
);
    logic                  grp_valid;
    logic [WIDTH-1:0]      is_branch;
    logic [WIDTH-1:0]      pred_taken;
    logic                  grp_ready;
    logic [WIDTH*ID_W-1:0] ckpt_id;
    logic                  commit_valid;
    logic                  mispred_valid;
    logic [ID_W-1:0]       mispred_id;
    logic                  mispred_taken;
    logic [HIST_LEN-1:0]   ghr_F;
    logic [ID_W:0]         ckpt_count;

    modport master (
        output grp_valid, is_branch, pred_taken, commit_valid,
               mispred_valid, mispred_id, mispred_taken,
        input  grp_ready, ckpt_id, ghr_F, ckpt_count
    );

    modport slave (
        input  grp_valid, is_branch, pred_taken, commit_valid,
               mispred_valid, mispred_id, mispred_taken,
        output grp_ready, ckpt_id, ghr_F, ckpt_count
    );
endinterface

// File: rtl/spec_ghr_ckpt_chk.sv
// Protocol checks for the speculative GHR: mispredicts must name a live
// checkpoint and the live count never exceeds the table depth.
module spec_ghr_ckpt_chk #(
    parameter int DEPTH = 8,
    parameter int ID_W  = $clog2(DEPTH)
) (
    input logic            clock,
    input logic            reset,
    input logic            mispred_valid,
    input logic [ID_W-1:0] mispred_id,
    input logic [ID_W-1:0] head,
    input logic [ID_W:0]   count
);
    logic [ID_W-1:0] dist_s;
    assign dist_s = mispred_id - head;

    // Sampled on the clock edge while out of reset.
    always @(posedge clock) begin
        if (reset) begin
            if (mispred_valid) begin
                assert ({1'b0, dist_s} < count)
                else $error("mispred_id %0d is not a live checkpoint", mispred_id);
            end
            assert (count <= (ID_W+1)'(DEPTH))
            else $error("checkpoint count %0d exceeds depth", count);
        end
    end
endmodule

// File: rtl/spec_ghr_ckpt_table.sv
// Checkpoint register file: DEPTH entries of HIST_LEN bits, WIDTH write ports
// (one per fetch lane, distinct addresses) and one asynchronous read port.
module ghr_ckpt_table #(
    parameter int HIST_LEN = 5,
    parameter int WIDTH    = 2,
    parameter int DEPTH    = 8,
    parameter int ID_W     = $clog2(DEPTH)
) (
    input  logic                      clock,
    input  logic [WIDTH-1:0]          wr_en,
    input  logic [WIDTH*ID_W-1:0]     wr_addr,
    input  logic [WIDTH*HIST_LEN-1:0] wr_data,
    input  logic [ID_W-1:0]           rd_addr,
    output logic [HIST_LEN-1:0]       rd_data
);
    logic [HIST_LEN-1:0] mem_r [DEPTH];

    // Lane writes; contents need no reset since every entry is written before use.
    always_ff @(posedge clock) begin
        for (int e = 32'sd0; e < DEPTH; e++) begin
            for (int p = 32'sd0; p < WIDTH; p++) begin
                if (wr_en[p] && (wr_addr[p*ID_W +: ID_W] == ID_W'(e))) begin
                    mem_r[e] <= wr_data[p*HIST_LEN +: HIST_LEN];
                end
            end
        end
    end

    assign rd_data = mem_r[rd_addr];
endmodule

// File: rtl/spec_ghr_ckpt.sv
// Speculative global history register with per-branch checkpoints; restores
// checkpoint+actual outcome on a mispredict and frees all younger entries.
module spec_ghr_ckpt
    import spec_ghr_ckpt_pkg::*;
#(
    parameter int HIST_LEN = HIST_LEN_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ID_W     = $clog2(DEPTH)
) (
    input logic           clock,
    input logic           reset,
    spec_ghr_ckpt_if.slave bus
);
    logic [HIST_LEN-1:0]       spec_r, ghr_f_r;
    logic [ID_W-1:0]           head_r, tail_r;
    logic [ID_W:0]             count_r;

    logic                      grp_ready_s, accept_s, commit_s;
    logic [ID_W:0]             k_s;
    logic [HIST_LEN-1:0]       grp_hist_s, restore_s, rd_data_s;
    logic [WIDTH-1:0]          wr_en_s;
    logic [WIDTH*ID_W-1:0]     wr_addr_s;
    logic [WIDTH*HIST_LEN-1:0] wr_data_s;
    logic [ID_W-1:0]           mis_dist_s;
    logic [HIST_LEN-1:0]       spec_nxt_s;
    logic [ID_W-1:0]           head_nxt_s, tail_nxt_s;
    logic [ID_W:0]             count_nxt_s;

    assign grp_ready_s = !bus.mispred_valid && (count_r <= (ID_W+1)'(DEPTH - WIDTH));
    assign accept_s    = bus.grp_valid && grp_ready_s;
    assign commit_s    = bus.commit_valid && (count_r != {(ID_W+1){1'b0}});
    assign mis_dist_s  = bus.mispred_id - head_r;
    assign restore_s   = HIST_LEN'(shift_in_outcomes(HIST_MAX'(rd_data_s), 8'd1,
                                                     {7'd0, bus.mispred_taken}, 32'd1));

    // Walk the lanes oldest-first: each branch snapshots the running history, then shifts.
    always_comb begin
        logic [HIST_LEN-1:0] h_v;
        h_v       = spec_r;
        k_s       = {(ID_W+1){1'b0}};
        wr_en_s   = {WIDTH{1'b0}};
        wr_addr_s = {(WIDTH*ID_W){1'b0}};
        wr_data_s = {(WIDTH*HIST_LEN){1'b0}};
        for (int i = 32'sd0; i < WIDTH; i++) begin
            wr_en_s[i]                       = accept_s && bus.is_branch[i];
            wr_addr_s[i*ID_W +: ID_W]        = tail_r + k_s[ID_W-1:0];
            wr_data_s[i*HIST_LEN +: HIST_LEN] = h_v;
            h_v = HIST_LEN'(shift_in_outcomes(HIST_MAX'(h_v), {7'd0, bus.is_branch[i]},
                                              {7'd0, bus.pred_taken[i]}, 32'd1));
            k_s = k_s + {{ID_W{1'b0}}, bus.is_branch[i]};
        end
        grp_hist_s = h_v;
    end

    // Next-state selection; mispredict recovery wins over group acceptance.
    always_comb begin
        spec_nxt_s  = spec_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r - (ID_W+1)'(commit_s);
        head_nxt_s  = head_r + ID_W'(commit_s);
        if (bus.mispred_valid) begin
            spec_nxt_s  = restore_s;
            tail_nxt_s  = bus.mispred_id + {{(ID_W-1){1'b0}}, 1'b1};
            count_nxt_s = {1'b0, mis_dist_s} + {{ID_W{1'b0}}, 1'b1} - (ID_W+1)'(commit_s);
        end else if (accept_s) begin
            spec_nxt_s  = grp_hist_s;
            tail_nxt_s  = tail_r + k_s[ID_W-1:0];
            count_nxt_s = count_r + k_s - (ID_W+1)'(commit_s);
        end else begin
            spec_nxt_s  = spec_r;
            tail_nxt_s  = tail_r;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            spec_r  <= {HIST_LEN{1'b0}};
            ghr_f_r <= {HIST_LEN{1'b0}};
            head_r  <= {ID_W{1'b0}};
            tail_r  <= {ID_W{1'b0}};
            count_r <= {(ID_W+1){1'b0}};
        end else begin
            spec_r  <= spec_nxt_s;
            ghr_f_r <= spec_r;
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    ghr_ckpt_table #(
        .HIST_LEN (HIST_LEN),
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ID_W     (ID_W)
    ) u_table (
        .clock   (clock),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .rd_addr (bus.mispred_id),
        .rd_data (rd_data_s)
    );

    spec_ghr_ckpt_chk #(
        .DEPTH (DEPTH),
        .ID_W  (ID_W)
    ) u_chk (
        .clock         (clock),
        .reset         (reset),
        .mispred_valid (bus.mispred_valid),
        .mispred_id    (bus.mispred_id),
        .head          (head_r),
        .count         (count_r)
    );

    assign bus.grp_ready  = grp_ready_s;
    assign bus.ckpt_id    = wr_addr_s;
    assign bus.ghr_F      = ghr_f_r;
    assign bus.ckpt_count = count_r;
endmodule

// File: tb/tb_spec_ghr_ckpt.sv
// Directed bench for spec_ghr_ckpt with HIST_LEN=5, WIDTH=2, DEPTH=4.
module tb_spec_ghr_ckpt;
    logic clock;
    logic reset;
    int   compared;
    int   mismatched;

    spec_ghr_ckpt_if #(.HIST_LEN(5), .WIDTH(2), .ID_W(2)) bus_if ();

    spec_ghr_ckpt #(.HIST_LEN(5), .WIDTH(2), .DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus_if.grp_valid     = 1'b0;
        bus_if.is_branch     = 2'b00;
        bus_if.pred_taken    = 2'b00;
        bus_if.commit_valid  = 1'b0;
        bus_if.mispred_valid = 1'b0;
        bus_if.mispred_id    = 2'd0;
        bus_if.mispred_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        idle();
        reset = 1'b0;
        bus_if.grp_valid  = 1'b1;
        bus_if.is_branch  = 2'b11;
        bus_if.pred_taken = 2'b11;
        tick();
        tick();
        chk("rst_ghr", bus_if.ghr_F, 5'b00000);
        chk("rst_cnt", bus_if.ckpt_count, 3'd0);
        chk("rst_ready", bus_if.grp_ready, 1'b1);

        // Dual branch, t0=1 t1=0
        reset = 1'b1;
        bus_if.grp_valid  = 1'b1;
        bus_if.is_branch  = 2'b11;
        bus_if.pred_taken = 2'b01;
        #1;
        chk("dual_ids", bus_if.ckpt_id, 4'b0100);
        tick();
        chk("dual_cnt", bus_if.ckpt_count, 3'd2);
        chk("dual_ghr_lag", bus_if.ghr_F, 5'b00000);

        // Single branch on lane 1, taken
        bus_if.is_branch  = 2'b10;
        bus_if.pred_taken = 2'b10;
        #1;
        chk("single_id", bus_if.ckpt_id[3:2], 2'd2);
        tick();
        chk("single_cnt", bus_if.ckpt_count, 3'd3);
        chk("dual_ghr", bus_if.ghr_F, 5'b00010);
        chk("full_ready", bus_if.grp_ready, 1'b0);

        // Group offered while not ready is ignored
        bus_if.is_branch  = 2'b11;
        bus_if.pred_taken = 2'b11;
        tick();
        chk("single_ghr", bus_if.ghr_F, 5'b00101);
        chk("ignored_cnt", bus_if.ckpt_count, 3'd3);
        bus_if.grp_valid = 1'b0;
        tick();
        chk("ignored_ghr", bus_if.ghr_F, 5'b00101);

        // Mispredict id 1, actual taken
        bus_if.mispred_valid = 1'b1;
        bus_if.mispred_id    = 2'd1;
        bus_if.mispred_taken = 1'b1;
        #1;
        chk("mis_blocks_ready", bus_if.grp_ready, 1'b0);
        tick();
        idle();
        #1;
        chk("mis_cnt", bus_if.ckpt_count, 3'd2);
        chk("mis_ready", bus_if.grp_ready, 1'b1);
        tick();
        chk("mis_ghr", bus_if.ghr_F, 5'b00011);

        // Commit and mispredict of id 1 together, actual not-taken
        bus_if.commit_valid  = 1'b1;
        bus_if.mispred_valid = 1'b1;
        bus_if.mispred_id    = 2'd1;
        bus_if.mispred_taken = 1'b0;
        tick();
        idle();
        chk("cm_cnt", bus_if.ckpt_count, 3'd1);
        tick();
        chk("cm_ghr", bus_if.ghr_F, 5'b00010);

        // Tail wraps 3 -> 0 while committing
        bus_if.grp_valid    = 1'b1;
        bus_if.is_branch    = 2'b11;
        bus_if.pred_taken   = 2'b11;
        bus_if.commit_valid = 1'b1;
        #1;
        chk("wrap_ids", bus_if.ckpt_id, 4'b1110);
        tick();
        chk("wrap_cnt1", bus_if.ckpt_count, 3'd2);

        bus_if.is_branch  = 2'b01;
        bus_if.pred_taken = 2'b00;
        #1;
        chk("wrap_reuse0", bus_if.ckpt_id[1:0], 2'd0);
        tick();
        chk("wrap_cnt2", bus_if.ckpt_count, 3'd2);
        chk("wrap_ghr1", bus_if.ghr_F, 5'b01011);

        bus_if.commit_valid = 1'b0;
        bus_if.is_branch    = 2'b11;
        bus_if.pred_taken   = 2'b01;
        #1;
        chk("wrap_ids2", bus_if.ckpt_id, 4'b1001);
        tick();
        chk("wrap_cnt_full", bus_if.ckpt_count, 3'd4);
        chk("wrap_ready", bus_if.grp_ready, 1'b0);
        chk("wrap_ghr2", bus_if.ghr_F, 5'b10110);

        // Mispredict on a wrapped entry (head=3, id=2); group offer ignored
        bus_if.mispred_valid = 1'b1;
        bus_if.mispred_id    = 2'd2;
        bus_if.mispred_taken = 1'b1;
        tick();
        idle();
        chk("wmis_cnt", bus_if.ckpt_count, 3'd4);
        chk("wmis_ghr_prev", bus_if.ghr_F, 5'b11010);
        tick();
        chk("wmis_ghr", bus_if.ghr_F, 5'b11011);

        // Reset during a mispredict
        reset = 1'b0;
        bus_if.grp_valid     = 1'b1;
        bus_if.is_branch     = 2'b11;
        bus_if.commit_valid  = 1'b1;
        bus_if.mispred_valid = 1'b1;
        bus_if.mispred_id    = 2'd3;
        bus_if.mispred_taken = 1'b1;
        tick();
        chk("mrst_ghr", bus_if.ghr_F, 5'b00000);
        chk("mrst_cnt", bus_if.ckpt_count, 3'd0);
        reset = 1'b1;
        idle();
        #1;
        chk("mrst_ready", bus_if.grp_ready, 1'b1);
        tick();
        chk("mrst_spec", bus_if.ghr_F, 5'b00000);

        bus_if.grp_valid  = 1'b1;
        bus_if.is_branch  = 2'b01;
        bus_if.pred_taken = 2'b01;
        #1;
        chk("mrst_tail", bus_if.ckpt_id[1:0], 2'd0);
        tick();
        idle();
        chk("post_cnt", bus_if.ckpt_count, 3'd1);
        tick();
        chk("post_ghr", bus_if.ghr_F, 5'b00001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
